led_pwm_dimmer: RTL and testbench



---
 rtl/io_pkg.sv | 25 ++
 rtl/led_pwm_timebase.sv | 62 ++++++
 rtl/led_pwm_dimmer.sv | 135 +++++++++++++
 tb/tb_led_pwm_dimmer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared IO definitions: control register map and LED group layout used by the
// LED dimmer and its timebase.
package io_pkg;

    typedef enum logic [1:0] {
        LED_CTRL_BRIGHT = 2'b00,
        LED_CTRL_BLINK  = 2'b01,
        LED_CTRL_RSVD2  = 2'b10,
        LED_CTRL_RSVD3  = 2'b11
    } led_ctrl_addr_e;

    localparam int LED_GROUPS = 3;
    localparam int GROUP_W    = 8;
    localparam int LED_W      = LED_GROUPS * GROUP_W;

    localparam int GROUP0_LO = 0;
    localparam int GROUP1_LO = GROUP_W;
    localparam int GROUP2_LO = 2 * GROUP_W;

    // Low bit of group g inside the 24-bit LED word.
    function automatic int group_lo(input int g);
        return g * GROUP_W;
    endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Free-running PWM timebase: prescaler, PWM slot counter and blink half-period
// counter with its phase flag (phase 1 = LEDs allowed on).
module led_pwm_timebase #(
    parameter int PWM_DIV       = 64,
    parameter int PWM_BITS      = 4,
    parameter int BLINK_PERIODS = 5600
) (
    input  logic                led_clk,
    input  logic                ledrst,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm_tick,
    output logic                period_end,
    output logic                blink_phase
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_PERIODS - 1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
    logic                phase_q, phase_d;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        pwm_tick   = (pre_q == PRE_LAST);
        period_end = pwm_tick && (pwm_cnt_q == '1);
        pre_d      = pwm_tick ? '0 : pre_q + 1'b1;
        pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(pwm_tick);
        blk_cnt_d  = blk_cnt_q;
        phase_d    = phase_q;
        if (period_end) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, avoiding read/write races between flops.
    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            pre_q     <= '0;
            pwm_cnt_q <= '0;
            blk_cnt_q <= '0;
            phase_q   <= 1'b1;
        end else begin
            pre_q     <= pre_d;
            pwm_cnt_q <= pwm_cnt_d;
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
        end
    end

    assign pwm_cnt     = pwm_cnt_q;
    assign blink_phase = phase_q;

endmodule

// File: rtl/led_pwm_dimmer.sv
// LED PWM dimmer: per-group brightness and blink on the 24-bit LED word, with
// BRIGHT/BLINK control registers. Optional macro LED_FADE_EN ramps brightness.
module led_pwm_dimmer
    import io_pkg::*;
#(
    parameter int PWM_DIV       = 64,
    parameter int PWM_BITS      = 4,
    parameter int BLINK_PERIODS = 5600
) (
    input  logic              led_clk,
    input  logic              ledrst,
    input  logic [LED_W-1:0]  ledin,
    input  logic              ctrlcs,
    input  logic              ctrlwrite,
    input  logic [1:0]        ctrladdr,
    input  logic [15:0]       ctrlwdata,
    output logic [15:0]       ctrlrdata,
    output logic [LED_W-1:0]  ledphys
);

    localparam int BRIGHT_W = LED_GROUPS * PWM_BITS;

    logic [BRIGHT_W-1:0]   bright_q, bright_d;
    logic [LED_GROUPS-1:0] blink_q, blink_d;
    logic [LED_W-1:0]      ledphys_q, ledphys_d;
    logic [BRIGHT_W-1:0]   eff_bright;
    logic [LED_GROUPS-1:0] g_on;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_tick;
    logic                period_end;
    logic                blink_phase;
    logic                unused_sigs;

    led_pwm_timebase #(
        .PWM_DIV       (PWM_DIV),
        .PWM_BITS      (PWM_BITS),
        .BLINK_PERIODS (BLINK_PERIODS)
    ) u_timebase (
        .led_clk     (led_clk),
        .ledrst      (ledrst),
        .pwm_cnt     (pwm_cnt),
        .pwm_tick    (pwm_tick),
        .period_end  (period_end),
        .blink_phase (blink_phase)
    );

    always_comb begin
        bright_d = bright_q;
        blink_d  = blink_q;
        if (ctrlcs && ctrlwrite) begin
            case (led_ctrl_addr_e'(ctrladdr))
                LED_CTRL_BRIGHT: bright_d = ctrlwdata[BRIGHT_W-1:0];
                LED_CTRL_BLINK:  blink_d  = ctrlwdata[LED_GROUPS-1:0];
                default: ;
            endcase
        end
    end

`ifdef LED_FADE_EN
    logic [BRIGHT_W-1:0] eff_q, eff_d;

    // Effective level walks one step per PWM period toward BRIGHT.
    always_comb begin
        eff_d = eff_q;
        if (period_end) begin
            for (int i = 0; i < LED_GROUPS; i++) begin
                if (eff_q[i*PWM_BITS +: PWM_BITS] < bright_q[i*PWM_BITS +: PWM_BITS])
                    eff_d[i*PWM_BITS +: PWM_BITS] = eff_q[i*PWM_BITS +: PWM_BITS] + 1'b1;
                else if (eff_q[i*PWM_BITS +: PWM_BITS] > bright_q[i*PWM_BITS +: PWM_BITS])
                    eff_d[i*PWM_BITS +: PWM_BITS] = eff_q[i*PWM_BITS +: PWM_BITS] - 1'b1;
            end
        end
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) eff_q <= '1;
        else        eff_q <= eff_d;
    end

    assign eff_bright  = eff_q;
    assign unused_sigs = pwm_tick ^ (^ctrlwdata);
`else
    assign eff_bright  = bright_q;
    assign unused_sigs = pwm_tick ^ period_end ^ (^ctrlwdata);
`endif

    // Full scale is a true 100% with no off-slot; zero is always off.
    function automatic logic group_on(input logic [PWM_BITS-1:0] level,
                                      input logic [PWM_BITS-1:0] slot,
                                      input logic                blink_en,
                                      input logic                phase);
        logic lit;
        if (level == '0)      lit = 1'b0;
        else if (level == '1) lit = 1'b1;
        else                  lit = (slot < level);
        return lit && (!blink_en || phase);
    endfunction

    always_comb begin
        g_on      = '0;
        ledphys_d = '0;
        for (int i = 0; i < LED_GROUPS; i++) begin
            g_on[i] = group_on(eff_bright[i*PWM_BITS +: PWM_BITS], pwm_cnt,
                               blink_q[i], blink_phase);
            ledphys_d[group_lo(i) +: GROUP_W] = ledin[group_lo(i) +: GROUP_W] & {GROUP_W{g_on[i]}};
        end
    end

    always_comb begin
        ctrlrdata = 16'h0000;
        if (ctrlcs && !ctrlwrite) begin
            case (led_ctrl_addr_e'(ctrladdr))
                LED_CTRL_BRIGHT: ctrlrdata[BRIGHT_W-1:0]   = bright_q;
                LED_CTRL_BLINK:  ctrlrdata[LED_GROUPS-1:0] = blink_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            bright_q  <= '1;
            blink_q   <= '0;
            ledphys_q <= '0;
        end else begin
            bright_q  <= bright_d;
            blink_q   <= blink_d;
            ledphys_q <= ledphys_d;
        end
    end

    assign ledphys = ledphys_q;

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Self-checking bench for led_pwm_dimmer; the reference model derives all LED
// timing from the cycle count since reset release.
module tb_led_pwm_dimmer;

    localparam int DIV    = 2;
    localparam int BITS   = 4;
    localparam int BP     = 2;
    localparam int PERIOD = DIV * (1 << BITS);
`ifdef LED_FADE_EN
    localparam int SETTLE = 16 * PERIOD;
`else
    localparam int SETTLE = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] ledin = '0;
    logic        ctrlcs = 1'b0;
    logic        ctrlwrite = 1'b0;
    logic [1:0]  ctrladdr = '0;
    logic [15:0] ctrlwdata = '0;
    logic [15:0] ctrlrdata;
    logic [23:0] ledphys;

    int checks = 0;
    int errors = 0;

    led_pwm_dimmer #(
        .PWM_DIV       (DIV),
        .PWM_BITS      (BITS),
        .BLINK_PERIODS (BP)
    ) dut (
        .led_clk   (clk),
        .ledrst    (rst),
        .ledin     (ledin),
        .ctrlcs    (ctrlcs),
        .ctrlwrite (ctrlwrite),
        .ctrladdr  (ctrladdr),
        .ctrlwdata (ctrlwdata),
        .ctrlrdata (ctrlrdata),
        .ledphys   (ledphys)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          cyc;
    logic [11:0] m_bright, m_eff, m_level;
    logic [2:0]  m_blink;
    logic [23:0] exp_ledphys;
    int          m_slot, m_lvl, m_e, m_t;
    bit          m_phase, m_on;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc         = 0;
            m_bright    = 12'hFFF;
            m_eff       = 12'hFFF;
            m_blink     = 3'b000;
            exp_ledphys = 24'h000000;
        end else begin
            m_slot  = (cyc / DIV) % (1 << BITS);
            m_phase = ((cyc / (PERIOD * BP)) % 2) == 0;
`ifdef LED_FADE_EN
            m_level = m_eff;
`else
            m_level = m_bright;
`endif
            for (int g = 0; g < 3; g++) begin
                m_lvl = int'(m_level[4*g +: 4]);
                m_on  = (m_lvl == 15) || (m_lvl != 0 && m_slot < m_lvl);
                if (m_blink[g] && !m_phase) m_on = 1'b0;
                exp_ledphys[8*g +: 8] = m_on ? ledin[8*g +: 8] : 8'h00;
            end
            if ((cyc % PERIOD) == PERIOD - 1) begin
                for (int g = 0; g < 3; g++) begin
                    m_e = int'(m_eff[4*g +: 4]);
                    m_t = int'(m_bright[4*g +: 4]);
                    if (m_e < m_t) m_e++;
                    else if (m_e > m_t) m_e--;
                    m_eff[4*g +: 4] = 4'(m_e);
                end
            end
            if (ctrlcs && ctrlwrite) begin
                if (ctrladdr == 2'b00) m_bright = ctrlwdata[11:0];
                if (ctrladdr == 2'b01) m_blink  = ctrlwdata[2:0];
            end
            cyc++;
        end
    end

    function automatic logic [15:0] exp_rd(input logic [1:0] a);
        case (a)
            2'b00:   return {4'h0, m_bright};
            2'b01:   return {13'h0, m_blink};
            default: return 16'h0000;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
        ctrlcs    = 1'b1;
        ctrlwrite = 1'b1;
        ctrladdr  = a;
        ctrlwdata = d;
        @(negedge clk);
        ctrlcs    = 1'b0;
        ctrlwrite = 1'b0;
        ctrlwdata = '0;
    endtask

    task automatic run_model_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            checks++;
            if (ledphys !== exp_ledphys) begin
                errors++;
                $display("FAIL model_cycle: ledphys=%h expected %h (cyc %0d)", ledphys, exp_ledphys, cyc);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if (ledphys !== 24'h000000) begin
            errors++;
            $display("FAIL reset_ledphys: got %h expected 000000", ledphys);
        end
        repeat (2) @(negedge clk);
        ctrlcs = 1'b1; ctrlwrite = 1'b0; ctrladdr = 2'b01;
        #1;
        checks++;
        if (ctrlrdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_blink_rd: got %h expected 0000", ctrlrdata);
        end
        ctrlcs = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_passthrough;
        ledin = 24'hA5C3F0;
        @(negedge clk);
        checks++;
        if (ledphys !== 24'hA5C3F0) begin
            errors++;
            $display("FAIL passthrough: got %h expected a5c3f0", ledphys);
        end
        ctrlcs = 1'b1; ctrlwrite = 1'b0; ctrladdr = 2'b00;
        #1;
        checks++;
        if (ctrlrdata !== 16'h0FFF) begin
            errors++;
            $display("FAIL bright_rd_default: got %h expected 0fff", ctrlrdata);
        end
        ctrlcs = 1'b0;
        run_model_cycles(8);
    endtask

    task automatic test_bright_pwm;
        int on0, on1, on2;
        on0 = 0; on1 = 0; on2 = 0;
        ledin = 24'hFFFFFF;
        write_reg(2'b00, 16'h0F40);
        run_model_cycles(SETTLE);
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            checks++;
            if (ledphys !== exp_ledphys) begin
                errors++;
                $display("FAIL bright_cycle: ledphys=%h expected %h", ledphys, exp_ledphys);
            end
            if (ledphys[7:0]   == 8'hFF) on0++;
            if (ledphys[15:8]  == 8'hFF) on1++;
            if (ledphys[23:16] == 8'hFF) on2++;
        end
        checks++;
        if (on0 !== 0)      begin errors++; $display("FAIL duty_group0: on %0d cycles, expected 0", on0); end
        checks++;
        if (on1 !== 4*DIV)  begin errors++; $display("FAIL duty_group1: on %0d cycles, expected %0d", on1, 4*DIV); end
        checks++;
        if (on2 !== PERIOD) begin errors++; $display("FAIL duty_group2: on %0d cycles, expected %0d", on2, PERIOD); end
    endtask

    task automatic test_blink;
        int on0;
        on0 = 0;
        write_reg(2'b00, 16'h0FFF);
        write_reg(2'b01, 16'h0001);
        run_model_cycles(SETTLE);
        for (int k = 0; k < 2 * PERIOD * BP; k++) begin
            @(negedge clk);
            checks++;
            if (ledphys !== exp_ledphys) begin
                errors++;
                $display("FAIL blink_cycle: ledphys=%h expected %h", ledphys, exp_ledphys);
            end
            checks++;
            if (ledphys[23:8] !== 16'hFFFF) begin
                errors++;
                $display("FAIL blink_others_on: got %h expected ffff", ledphys[23:8]);
            end
            if (ledphys[7:0] == 8'hFF) on0++;
        end
        checks++;
        if (on0 !== PERIOD * BP) begin
            errors++;
            $display("FAIL blink_duty: on %0d cycles, expected %0d", on0, PERIOD * BP);
        end
    endtask

    task automatic test_ignored_write;
        write_reg(2'b10, 16'hFFFF);
        write_reg(2'b11, 16'hFFFF);
        for (int a = 0; a < 4; a++) begin
            ctrlcs = 1'b1; ctrlwrite = 1'b0; ctrladdr = 2'(a);
            #1;
            checks++;
            if (ctrlrdata !== exp_rd(2'(a))) begin
                errors++;
                $display("FAIL ignored_write_rd%0d: got %h expected %h", a, ctrlrdata, exp_rd(2'(a)));
            end
        end
        checks++;
        if (ctrlrdata !== 16'h0000) begin
            errors++;
            $display("FAIL rd_addr3: got %h expected 0000", ctrlrdata);
        end
        ctrlcs = 1'b1; ctrlwrite = 1'b1; ctrladdr = 2'b00;
        #1;
        checks++;
        if (ctrlrdata !== 16'h0000) begin
            errors++;
            $display("FAIL rd_during_write: got %h expected 0000", ctrlrdata);
        end
        ctrlcs = 1'b0; ctrlwrite = 1'b0;
        run_model_cycles(4);
    endtask

    task automatic test_random;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            checks++;
            if (ledphys !== exp_ledphys) begin
                errors++;
                $display("FAIL random_cycle %0d: ledphys=%h expected %h", k, ledphys, exp_ledphys);
            end
            ledin     = 24'($urandom);
            ctrlcs    = 1'b0;
            ctrlwrite = 1'b0;
            if ($urandom_range(0, 15) == 0) begin
                ctrlcs    = 1'b1;
                ctrlwrite = 1'b1;
                ctrladdr  = 2'($urandom_range(0, 3));
                ctrlwdata = 16'($urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                ctrlcs   = 1'b1;
                ctrladdr = 2'($urandom_range(0, 3));
                #1;
                checks++;
                if (ctrlrdata !== exp_rd(ctrladdr)) begin
                    errors++;
                    $display("FAIL random_rd: addr %0d got %h expected %h", ctrladdr, ctrlrdata, exp_rd(ctrladdr));
                end
            end
        end
        @(negedge clk);
        ctrlcs = 1'b0; ctrlwrite = 1'b0; ctrlwdata = '0;
        write_reg(2'b01, 16'h0000);
        run_model_cycles(4);
    endtask

`ifdef LED_FADE_EN
    task automatic test_fade;
        int on0;
        int want[4];
        want = '{14*DIV, 13*DIV, 12*DIV, 12*DIV};
        ledin = 24'hFFFFFF;
        write_reg(2'b00, 16'h0FFF);
        run_model_cycles(SETTLE);
        for (int k = 0; k < PERIOD && (cyc % PERIOD) != 8; k++) @(negedge clk);
        write_reg(2'b00, 16'h0FFC);
        for (int k = 0; k < PERIOD && (cyc % PERIOD) != 0; k++) @(negedge clk);
        checks++;
        if ((cyc % PERIOD) != 0) begin
            errors++;
            $display("FAIL fade_align: timed out waiting for period start");
        end
        for (int p = 0; p < 4; p++) begin
            on0 = 0;
            for (int k = 0; k < PERIOD; k++) begin
                @(negedge clk);
                if (ledphys[7:0] == 8'hFF) on0++;
            end
            checks++;
            if (on0 !== want[p]) begin
                errors++;
                $display("FAIL fade_period%0d: on %0d cycles, expected %0d", p, on0, want[p]);
            end
        end
    endtask
`endif

    task automatic test_reset_mid;
        ledin = 24'hFFFFFF;
        write_reg(2'b00, 16'h0FFF);
        write_reg(2'b01, 16'h0001);
        run_model_cycles(SETTLE);
        for (int k = 0; k < 2 * PERIOD * BP && ((cyc / (PERIOD * BP)) % 2) != 1; k++) @(negedge clk);
        run_model_cycles(3);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ledphys !== 24'h000000) begin
            errors++;
            $display("FAIL reset_mid_async: got %h expected 000000", ledphys);
        end
        @(negedge clk);
        rst = 1'b0;
        ctrlcs = 1'b1; ctrlwrite = 1'b0; ctrladdr = 2'b00;
        #1;
        checks++;
        if (ctrlrdata !== 16'h0FFF) begin
            errors++;
            $display("FAIL reset_mid_bright: got %h expected 0fff", ctrlrdata);
        end
        ctrlcs = 1'b0;
        ledin = 24'h5A3C96;
        @(negedge clk);
        checks++;
        if (ledphys !== 24'h5A3C96) begin
            errors++;
            $display("FAIL reset_mid_follow: got %h expected 5a3c96", ledphys);
        end
        write_reg(2'b00, 16'h0000);
        run_model_cycles(SETTLE + 4);
        rst = 1'b1;
        #1;
        checks++;
        if (ledphys !== 24'h000000) begin
            errors++;
            $display("FAIL reset_dark: got %h expected 000000", ledphys);
        end
        @(negedge clk);
        rst = 1'b0;
        run_model_cycles(4);
        checks++;
        if (ledphys !== 24'h5A3C96) begin
            errors++;
            $display("FAIL reset_dark_follow: got %h expected 5a3c96", ledphys);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_bright_pwm();
        test_blink();
        test_ignored_write();
        test_random();
`ifdef LED_FADE_EN
        test_fade();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
